// File: rtl/mac2_pkg.sv
// Shared types and the round-robin pick helper for the mac2 sharing sequencer.
// rr_pick is sized for the largest supported requester count (8).
package mac2_pkg;

    typedef enum logic {
        OP_MUL = 1'b0,
        OP_INC = 1'b1
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int MAX_REQ = 8;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } pick_t;

    // Circular scan starting at ptr; ptr < n is assumed, so one wrap subtract suffices.
    function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                      input logic [2:0]         ptr,
                                      input int                 n);
        pick_t p;
        int    k;
        p = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            k = int'(ptr) + i;
            if (k >= n) begin
                k = k - n;
            end
            if ((i < n) && !p.found && valid[k[2:0]]) begin
                p.found = 1'b1;
                p.idx   = k[2:0];
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/mac2_unit.sv
// Shared 2-bit modular arithmetic: MUL -> (a*b) mod 4, INC -> (a+cin) mod 4.
module mac2_unit
    import mac2_pkg::*;
(
    input  op_e        op,
    input  logic [1:0] a,
    input  logic [1:0] b,
    input  logic       cin,
    output logic [1:0] res
);

    logic [1:0] mul_res;
    logic [1:0] inc_res;

    // Two-bit result context drops the high product bits and the carry-out.
    always_comb begin
        mul_res = a * b;
        inc_res = a + {1'b0, cin};
        res     = (op == OP_MUL) ? mul_res : inc_res;
    end

endmodule

// File: rtl/mac2_share_sched.sv
// Round-robin sequencer granting N_REQ requesters access to one mac2_unit,
// with a registered execute stage and a single backpressured response register.
module mac2_share_sched
    import mac2_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req_valid,
    output logic [N_REQ-1:0]   req_ready,
    input  logic [N_REQ-1:0]   req_op,
    input  logic [2*N_REQ-1:0] req_a,
    input  logic [2*N_REQ-1:0] req_b,
    input  logic [N_REQ-1:0]   req_cin,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [ID_W-1:0]    rsp_id,
    output logic               rsp_op,
    output logic [1:0]         rsp_res,
    output logic               busy
);

    state_e          state_q,   state_d;
    logic [ID_W-1:0] rr_ptr_q,  rr_ptr_d;
    op_e             op_q,      op_d;
    logic [1:0]      a_q,       a_d;
    logic [1:0]      b_q,       b_d;
    logic            cin_q,     cin_d;
    logic [ID_W-1:0] id_q,      id_d;
    logic [1:0]      rsp_res_q, rsp_res_d;
    logic [ID_W-1:0] rsp_id_q,  rsp_id_d;
    logic            rsp_op_q,  rsp_op_d;

    logic [MAX_REQ-1:0] valid_ext;
    pick_t              pick;
    logic               grant_slot;
    logic [1:0]         unit_res;
    int                 win;

    mac2_unit u_unit (
        .op  (op_q),
        .a   (a_q),
        .b   (b_q),
        .cin (cin_q),
        .res (unit_res)
    );

    always_comb begin
        valid_ext               = '0;
        valid_ext[N_REQ-1:0]    = req_valid;
        pick                    = rr_pick(valid_ext, 3'(rr_ptr_q), N_REQ);
        win                     = int'(pick.idx);
        // Grants happen from IDLE, or from RESP in the cycle the result is taken;
        // rst_n gating keeps req_ready low while reset is held.
        grant_slot = rst_n && ((state_q == IDLE) ||
                               ((state_q == RESP) && rsp_ready));
    end

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        cin_d     = cin_q;
        id_d      = id_q;
        rsp_res_d = rsp_res_q;
        rsp_id_d  = rsp_id_q;
        rsp_op_d  = rsp_op_q;
        req_ready = '0;

        case (state_q)
            IDLE, RESP: begin
                if (grant_slot && pick.found) begin
                    req_ready[win] = 1'b1;
                    op_d           = op_e'(req_op[win]);
                    a_d            = req_a[2*win +: 2];
                    b_d            = req_b[2*win +: 2];
                    cin_d          = req_cin[win];
                    id_d           = pick.idx[ID_W-1:0];
                    state_d        = EXEC;
                end else if (state_q == RESP && rsp_ready) begin
                    state_d = IDLE;
                end
            end
            EXEC: begin
                rsp_res_d = unit_res;
                rsp_id_d  = id_q;
                rsp_op_d  = op_q;
                rr_ptr_d  = (id_q == ID_W'(N_REQ-1)) ? '0 : id_q + 1'b1;
                state_d   = RESP;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rr_ptr_q  <= '0;
            op_q      <= OP_MUL;
            a_q       <= '0;
            b_q       <= '0;
            cin_q     <= 1'b0;
            id_q      <= '0;
            rsp_res_q <= '0;
            rsp_id_q  <= '0;
            rsp_op_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            cin_q     <= cin_d;
            id_q      <= id_d;
            rsp_res_q <= rsp_res_d;
            rsp_id_q  <= rsp_id_d;
            rsp_op_q  <= rsp_op_d;
        end
    end

    assign rsp_valid = (state_q == RESP);
    assign rsp_res   = rsp_res_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_op    = rsp_op_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mac2_share_sched.sv
// Directed bench for mac2_share_sched (4- and 3-requester builds) and mac2_unit.
module tb_mac2_share_sched;
    import mac2_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- 4-requester DUT ----------------
    logic [3:0] req_valid = '0, req_ready, req_op = '0, req_cin = '0;
    logic [7:0] req_a = '0, req_b = '0;
    logic       rsp_valid, rsp_ready = 1'b1, rsp_op, busy;
    logic [1:0] rsp_id, rsp_res;

    mac2_share_sched #(.N_REQ(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_op(rsp_op), .rsp_res(rsp_res), .busy(busy)
    );

    // ---------------- 3-requester DUT ----------------
    logic [2:0] req_valid3 = '0, req_ready3, req_op3 = '0, req_cin3 = '0;
    logic [5:0] req_a3 = '0, req_b3 = '0;
    logic       rsp_valid3, rsp_ready3 = 1'b1, rsp_op3, busy3;
    logic [1:0] rsp_id3, rsp_res3;

    mac2_share_sched #(.N_REQ(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid3), .req_ready(req_ready3), .req_op(req_op3),
        .req_a(req_a3), .req_b(req_b3), .req_cin(req_cin3),
        .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_id(rsp_id3),
        .rsp_op(rsp_op3), .rsp_res(rsp_res3), .busy(busy3)
    );

    // ---------------- stand-alone unit ----------------
    op_e        u_op = OP_MUL;
    logic [1:0] u_a = '0, u_b = '0, u_res;
    logic       u_cin = 1'b0;

    mac2_unit u_unit (.op(u_op), .a(u_a), .b(u_b), .cin(u_cin), .res(u_res));

    // ---------------- scoreboard ----------------
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [3:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_req(input int i, input logic op, input logic [1:0] a,
                           input logic [1:0] b, input logic cin);
        req_op[i]       = op;
        req_a[2*i +: 2] = a;
        req_b[2*i +: 2] = b;
        req_cin[i]      = cin;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        logic [3:0] exp_item;

        // ---- reset state, with a request asserted during reset ----
        req_valid = 4'b0001;
        #3;
        check("rst_req_ready", 32'(req_ready), 32'h0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_rsp_id",    32'(rsp_id),    32'h0);
        check("rst_rsp_op",    32'(rsp_op),    32'h0);
        check("rst_rsp_res",   32'(rsp_res),   32'h0);
        check("rst_busy",      32'(busy),      32'h0);
        req_valid = 4'b0000;
        step();
        rst_n = 1'b1;
        step();

        // ---- mac2_unit exhaustive: 32 MUL + 8 INC ----
        for (int a = 0; a < 4; a++) begin
            for (int b = 0; b < 4; b++) begin
                for (int c = 0; c < 2; c++) begin
                    u_op = OP_MUL; u_a = 2'(a); u_b = 2'(b); u_cin = 1'(c);
                    #1;
                    check("unit_mul", 32'(u_res), 32'((a * b) % 4));
                end
            end
        end
        for (int a = 0; a < 4; a++) begin
            for (int c = 0; c < 2; c++) begin
                u_op = OP_INC; u_a = 2'(a); u_b = 2'($urandom_range(0, 3)); u_cin = 1'(c);
                #1;
                check("unit_inc", 32'(u_res), 32'((a + c) % 4));
            end
        end

        // ---- single MUL from requester 2: 3*3 mod 4 = 1 ----
        set_req(2, 1'b0, 2'd3, 2'd3, 1'b1);
        req_valid = 4'b0100;
        #1;
        check("mul_grant", 32'(req_ready), 32'h4);
        step();
        req_valid = 4'b0000;
        #1;
        check("mul_exec_valid", 32'(rsp_valid), 32'h0);
        check("mul_exec_busy",  32'(busy),      32'h1);
        step();
        check("mul_rsp_valid", 32'(rsp_valid), 32'h1);
        check("mul_rsp_res",   32'(rsp_res),   32'h1);
        check("mul_rsp_id",    32'(rsp_id),    32'h2);
        check("mul_rsp_op",    32'(rsp_op),    32'h0);
        step();
        check("mul_back_idle", 32'(busy), 32'h0);

        // ---- INC requester 0: 3+1 wraps to 0, then 2+1 = 3 (b ignored) ----
        set_req(0, 1'b1, 2'd3, 2'd3, 1'b1);
        req_valid = 4'b0001;
        #1;
        check("inc_grant", 32'(req_ready), 32'h1);
        step();
        req_valid = 4'b0000;
        step();
        check("inc_rsp_res_wrap", 32'(rsp_res), 32'h0);
        check("inc_rsp_op",       32'(rsp_op),  32'h1);
        check("inc_rsp_id",       32'(rsp_id),  32'h0);
        set_req(0, 1'b1, 2'd2, 2'd1, 1'b1);
        req_valid = 4'b0001;
        #1;
        check("inc_regrant_in_resp", 32'(req_ready), 32'h1);
        step();
        req_valid = 4'b0000;
        #1;
        check("inc2_exec_valid", 32'(rsp_valid), 32'h0);
        step();
        check("inc2_rsp_res", 32'(rsp_res), 32'h3);
        step();

        // ---- async reset during EXEC with requests pending ----
        set_req(1, 1'b0, 2'd2, 2'd3, 1'b0);
        set_req(3, 1'b1, 2'd1, 2'd0, 1'b1);
        req_valid = 4'b1010;
        #1;
        check("pre_rst_grant", 32'(req_ready), 32'h2);
        step();
        rst_n = 1'b0;
        #1;
        check("arst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("arst_busy",      32'(busy),      32'h0);
        check("arst_req_ready", 32'(req_ready), 32'h0);
        check("arst_rsp_res",   32'(rsp_res),   32'h0);
        check("arst_rsp_id",    32'(rsp_id),    32'h0);
        step();
        rst_n = 1'b1;
        #1;
        check("post_rst_grant_low", 32'(req_ready), 32'h2);
        step();
        req_valid = 4'b0000;
        #1;
        check("post_rst_no_stale", 32'(rsp_valid), 32'h0);
        step();
        check("post_rst_rsp_id",  32'(rsp_id),  32'h1);
        check("post_rst_rsp_res", 32'(rsp_res), 32'h2);
        step();

        // ---- round-robin with all four valid ----
        do_reset();
        set_req(0, 1'b0, 2'd1, 2'd1, 1'b0);
        set_req(1, 1'b0, 2'd2, 2'd1, 1'b0);
        set_req(2, 1'b0, 2'd3, 2'd1, 1'b0);
        set_req(3, 1'b1, 2'd3, 2'd2, 1'b1);
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        #1;
        for (int g = 0; g < 8; g++) begin
            check("rr_grant", 32'(req_ready), 32'(1 << (g % 4)));
            case (g % 4)
                0: exp_q.push_back({2'd0, 2'd1});
                1: exp_q.push_back({2'd1, 2'd2});
                2: exp_q.push_back({2'd2, 2'd3});
                default: exp_q.push_back({2'd3, 2'd0});
            endcase
            step();
            check("rr_exec_ready", 32'(req_ready), 32'h0);
            check("rr_exec_valid", 32'(rsp_valid), 32'h0);
            step();
            check("rr_rsp_valid", 32'(rsp_valid), 32'h1);
            if (exp_q.size() == 0) begin
                check("rr_sb_underflow", 32'h1, 32'h0);
            end else begin
                exp_item = exp_q.pop_front();
                check("rr_rsp_id",  32'(rsp_id),  32'(exp_item[3:2]));
                check("rr_rsp_res", 32'(rsp_res), 32'(exp_item[1:0]));
            end
        end

        // ---- backpressure in RESP holding id 3, result 0 ----
        rsp_ready = 1'b0;
        #1;
        for (int c = 0; c < 5; c++) begin
            check("bp_no_grant",  32'(req_ready), 32'h0);
            check("bp_rsp_valid", 32'(rsp_valid), 32'h1);
            check("bp_rsp_id",    32'(rsp_id),    32'h3);
            check("bp_rsp_res",   32'(rsp_res),   32'h0);
            step();
        end
        rsp_ready = 1'b1;
        #1;
        check("bp_release_grant", 32'(req_ready), 32'h1);
        step();
        req_valid = 4'b0000;
        step();
        check("bp_next_rsp_id",  32'(rsp_id),  32'h0);
        check("bp_next_rsp_res", 32'(rsp_res), 32'h1);
        step();
        check("bp_idle", 32'(busy), 32'h0);

        // ---- 3-requester build: pointer wraps 2 -> 0 ----
        req_op3 = 3'b000; req_cin3 = 3'b000;
        req_a3 = {2'd3, 2'd2, 2'd1};
        req_b3 = {2'd1, 2'd1, 2'd1};
        req_valid3 = 3'b100;
        #1;
        check("n3_grant2", 32'(req_ready3), 32'h4);
        step();
        req_valid3 = 3'b110;
        step();
        check("n3_rsp_id2",  32'(rsp_id3),  32'h2);
        check("n3_rsp_res2", 32'(rsp_res3), 32'h3);
        #1;
        check("n3_wrap_grant1", 32'(req_ready3), 32'h2);
        step();
        step();
        check("n3_rsp_id1",  32'(rsp_id3),  32'h1);
        check("n3_rsp_res1", 32'(rsp_res3), 32'h2);
        check("n3_grant2_again", 32'(req_ready3), 32'h4);
        step();
        req_valid3 = 3'b000;
        step();
        check("n3_rsp_id2b", 32'(rsp_id3), 32'h2);
        step();
        check("n3_idle", 32'(busy3), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // The 3-requester build must never report an out-of-range id.
    always @(negedge clk) begin
        if (rst_n && rsp_valid3 && rsp_id3 == 2'd3) begin
            check("n3_id_range", 32'(rsp_id3), 32'h2);
        end
    end

endmodule

// File: doc/mac2_share_sched.md
Name: mac2_share_sched

Overview:
- Sequencer/arbiter that shares one 2-bit modular multiply/increment unit between N_REQ requesters.
- Multiply: (a*b) mod 4. Increment: (a + cin) mod 4.
- Round-robin arbitration, operand latching, a registered execute stage and one response register with valid/ready backpressure.
- Sits between the requester blocks and the shared 2-bit arithmetic datapath; the only legal path into that datapath.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- ID_W, $clog2(N_REQ), width of the requester index

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  N_REQ  per-requester request valid
- req_ready  out  N_REQ  per-requester grant/accept; at most one bit set
- req_op  in  N_REQ  per-requester op: 0=MUL, 1=INC
- req_a  in  2*N_REQ  operand a; requester i uses bits [2i+1:2i]
- req_b  in  2*N_REQ  operand b (MUL only); requester i uses bits [2i+1:2i]
- req_cin  in  N_REQ  carry-in (INC only)
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_id  out  ID_W  index of requester that owns the result
- rsp_op  out  1  op of the result
- rsp_res  out  2  result, bit0 = LSB
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; rr_ptr=0.
  - rsp_valid=0, rsp_id=0, rsp_op=0, rsp_res=0, req_ready=0, busy=0.
  - An operation in flight is discarded; nothing is replayed after reset.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any req_valid is high, grant the first valid index at or after rr_ptr (circular).
  - Drive req_ready[winner]=1 combinationally in this cycle; the handshake completes in this cycle.
  - Latch op/a/b/cin and winner id; go to EXEC.
  - If no req_valid is high, stay in IDLE.
- EXEC (1 cycle):
  - Compute from latched operands: MUL -> (a*b)[1:0]; INC -> (a+cin)[1:0]. The carry-out is dropped.
  - Register the result into rsp_res/rsp_id/rsp_op; go to RESP.
  - rr_ptr <= (winner+1) mod N_REQ.
- RESP:
  - rsp_valid=1; rsp_* held stable until accepted.
  - On rsp_ready=1:
    - If any req_valid is high, grant the next winner in this same cycle (req_ready pulse, latch) and go to EXEC.
    - Otherwise go to IDLE.
    - rsp_valid drops next cycle unless RESP is re-entered.
  - rsp_ready=0: hold; no grants issued.
- Latency and throughput:
  - Request accept to rsp_valid: 2 cycles.
  - Sustained throughput with rsp_ready=1: one result per 2 cycles.
- Requester obligations:
  - Hold req_valid and operands stable until req_ready.
  - Deassertion before grant is allowed; the block does not check it.
- Fairness: a requester that stays valid is granted within N_REQ grants.
- Simultaneous requests: resolved only by rr_ptr. No fixed priority beyond the circular scan.
- N_REQ not a power of 2: rr_ptr wraps at N_REQ-1 -> 0; ids >= N_REQ never appear.
- Operand ignore rules: req_b ignored for INC; req_cin ignored for MUL.

Decomposition:
- Shared package mac2_pkg:
  - op enum (OP_MUL=1'b0, OP_INC=1'b1)
  - state enum (IDLE, EXEC, RESP)
  - a function rr_pick(valid, ptr) returning winner index and found flag
- Sub-module mac2_unit: pure combinational 2-bit modular multiply/increment (inputs op, a, b, cin; output res[1:0]).
  - Instantiated once in EXEC.
  - Verified stand-alone exhaustively (32 MUL + 8 INC combinations).

Test Plan:
- Single MUL, requester 2, a=3, b=3, rsp_ready=1 -> req_ready[2] same cycle; 2 cycles later rsp_valid=1, rsp_res=1, rsp_id=2, rsp_op=0.
- INC, requester 0, a=3, cin=1 -> rsp_res=0 (wrap), rsp_op=1. Then a=2, cin=1 -> rsp_res=3.
- All four requesters valid continuously, rsp_ready=1, rr_ptr=0 -> grant order 0,1,2,3,0,...; each granted exactly once per 4 results; a new grant every 2 cycles.
- Backpressure: rsp_ready=0 for 5 cycles in RESP, others valid -> rsp_* stable, no req_ready pulses. On rsp_ready=1, next grant in the same cycle.
- Async reset asserted during EXEC with request pending -> all outputs 0 immediately. After release, IDLE, rr_ptr=0, first grant to lowest valid index, no stale rsp_valid.
- N_REQ=3 build, requesters 1 and 2 valid after a grant to 2 -> rr_ptr wraps to 0; next grant is 1; rsp_id never 3.
